// File: rtl/alu_serial_if.sv
// Handshake and operand/result bundle for the bit-serial ALU.
// The master drives a request, the slave (the ALU) returns result, flags and status.
interface alu_serial_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [3:0]       control;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, cin, control,
    input  result, cout, ovf, zero, busy, done
  );

  modport slave (
    input  start, a, b, cin, control,
    output result, cout, ovf, zero, busy, done
  );
endinterface

// File: rtl/alu_serial.sv
// Multi-cycle ALU: evaluates a WIDTH-bit AND/OR/ADD/SLT in SLICE-bit chunks, LSB first,
// with a registered ripple carry; result and flags update only when done pulses.
module alu_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_serial_if.slave  bus
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       ctrl_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;

  logic [SLICE-1:0] ain;
  logic [SLICE-1:0] bin;
  logic [SLICE-1:0] sliceSum;
  logic [SLICE-1:0] sliceOut;
  logic             cMsb;
  logic             cOut;
  logic             ovf_d;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] result_d;

  // Operands are shifted right each cycle, so the active slice always sits in the low bits.
  always_comb begin
    logic c;
    ain      = ctrl_q[3] ? ~opA_q[SLICE-1:0] : opA_q[SLICE-1:0];
    bin      = ctrl_q[2] ? ~opB_q[SLICE-1:0] : opB_q[SLICE-1:0];
    sliceSum = '0;
    c        = carry_q;
    cMsb     = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      if (i == SLICE - 1) cMsb = c;
      sliceSum[i] = ain[i] ^ bin[i] ^ c;
      c           = (ain[i] & bin[i]) | (c & (ain[i] ^ bin[i]));
    end
    cOut = c;

    case (ctrl_q[1:0])
      2'b00:   sliceOut = ain & bin;
      2'b01:   sliceOut = ain | bin;
      2'b10:   sliceOut = sliceSum;
      default: sliceOut = '0;
    endcase

    acc_d    = WIDTH'({sliceOut, acc_q} >> SLICE);
    ovf_d    = cMsb ^ cOut;
    result_d = (ctrl_q[1:0] == 2'b11) ? {{(WIDTH-1){1'b0}}, sliceSum[SLICE-1] ^ ovf_d}
                                      : acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opA_q    <= '0;
      opB_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ctrl_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            opA_q   <= bus.a;
            opB_q   <= bus.b;
            ctrl_q  <= bus.control;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          opA_q   <= opA_q >> SLICE;
          opB_q   <= opB_q >> SLICE;
          carry_q <= cOut;
          acc_q   <= acc_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          // Visible outputs only move here, so consumers see a stable result during RUN.
          if (cnt_q == LAST) begin
            result_q <= result_d;
            cout_q   <= cOut;
            ovf_q    <= ovf_d;
            zero_q   <= (result_d == '0);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial at WIDTH=8 with SLICE=1 and SLICE=4 instances,
// using a queue of expected results pushed at start and popped when done pulses.
module tb_alu_serial;

  localparam int W       = 8;
  localparam int TIMEOUT = 40;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   testsRun    = 0;
  int   testsFailed = 0;
  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  alu_serial_if #(.WIDTH(W)) bus1 ();
  alu_serial_if #(.WIDTH(W)) bus4 ();

  alu_serial #(.WIDTH(W), .SLICE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  alu_serial #(.WIDTH(W), .SLICE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  // Reference behaviour from plain word-level arithmetic and the sign rule for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic [3:0] ctl);
    exp_t       e;
    logic [W-1:0] ain;
    logic [W-1:0] bin;
    logic [W:0]   full;
    ain  = ctl[3] ? ~a : a;
    bin  = ctl[2] ? ~b : b;
    full = {1'b0, ain} + {1'b0, bin} + {{W{1'b0}}, cin};
    e.c  = full[W];
    e.o  = (ain[W-1] == bin[W-1]) && (full[W-1] != ain[W-1]);
    case (ctl[1:0])
      2'b00:   e.r = ain & bin;
      2'b01:   e.r = ain | bin;
      2'b10:   e.r = full[W-1:0];
      default: e.r = {{(W-1){1'b0}}, full[W-1] ^ e.o};
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic issue1(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [3:0] ctl, input exp_t e);
    @(negedge clk);
    bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.control = ctl;
    q1.push_back(e);
    @(negedge clk);
    bus1.start = 1'b0;
  endtask

  task automatic issue4(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [3:0] ctl, input exp_t e);
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.control = ctl;
    q4.push_back(e);
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  task automatic collect1(output exp_t got, output int cyc);
    cyc = 1;
    while (bus1.done !== 1'b1 && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    got = '{bus1.result, bus1.cout, bus1.ovf, bus1.zero};
  endtask

  task automatic collect4(output exp_t got, output int cyc);
    cyc = 1;
    while (bus4.done !== 1'b1 && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    got = '{bus4.result, bus4.cout, bus4.ovf, bus4.zero};
  endtask

  task automatic test_reset();
    #12;
    testsRun++;
    if (bus1.result !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_result: got %h, expected 00", bus1.result); end
    testsRun++;
    if ({bus1.cout, bus1.ovf, bus1.zero} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_flags: got %b, expected 000", {bus1.cout, bus1.ovf, bus1.zero}); end
    testsRun++;
    if ({bus1.busy, bus1.done, bus4.busy, bus4.done} !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_status: got %b, expected 0000", {bus1.busy, bus1.done, bus4.busy, bus4.done}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    exp_t got, e;
    logic [W-1:0] held;
    held = bus1.result;
    issue1(8'h7F, 8'h01, 1'b0, 4'b0010, '{8'h80, 1'b0, 1'b1, 1'b0});
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) @(negedge clk);
      testsRun++;
      if (bus1.busy !== (c <= 8)) begin testsFailed++; $display("[TB] FAIL add_busy cycle %0d: got %b, expected %b", c, bus1.busy, (c <= 8)); end
      testsRun++;
      if (bus1.done !== (c == 9)) begin testsFailed++; $display("[TB] FAIL add_done cycle %0d: got %b, expected %b", c, bus1.done, (c == 9)); end
      if (c <= 8) begin
        testsRun++;
        if (bus1.result !== held) begin testsFailed++; $display("[TB] FAIL add_hold cycle %0d: got %h, expected %h", c, bus1.result, held); end
      end
    end
    got = '{bus1.result, bus1.cout, bus1.ovf, bus1.zero};
    e   = q1.pop_front();
    testsRun++;
    if (got !== e) begin testsFailed++; $display("[TB] FAIL add_value: got r=%h c=%b o=%b z=%b, expected r=%h c=%b o=%b z=%b", got.r, got.c, got.o, got.z, e.r, e.c, e.o, e.z); end
  endtask

  task automatic test_sub();
    exp_t got, e;
    int   cyc;
    issue1(8'h05, 8'h05, 1'b1, 4'b0110, '{8'h00, 1'b1, 1'b0, 1'b1});
    collect1(got, cyc);
    testsRun++;
    if (cyc != 9) begin testsFailed++; $display("[TB] FAIL sub_latency: got cycle %0d, expected 9", cyc); end
    e = q1.pop_front();
    testsRun++;
    if (got !== e) begin testsFailed++; $display("[TB] FAIL sub_value: got r=%h c=%b o=%b z=%b, expected r=%h c=%b o=%b z=%b", got.r, got.c, got.o, got.z, e.r, e.c, e.o, e.z); end
  endtask

  task automatic test_sub_slice4();
    exp_t got, e;
    int   cyc;
    issue4(8'h05, 8'h05, 1'b1, 4'b0110, '{8'h00, 1'b1, 1'b0, 1'b1});
    collect4(got, cyc);
    testsRun++;
    if (cyc != 3) begin testsFailed++; $display("[TB] FAIL sub4_latency: got cycle %0d, expected 3", cyc); end
    e = q4.pop_front();
    testsRun++;
    if (got !== e) begin testsFailed++; $display("[TB] FAIL sub4_value: got r=%h c=%b o=%b z=%b, expected r=%h c=%b o=%b z=%b", got.r, got.c, got.o, got.z, e.r, e.c, e.o, e.z); end
    @(negedge clk);
    testsRun++;
    if (bus4.done !== 1'b0) begin testsFailed++; $display("[TB] FAIL sub4_done_width: got %b, expected 0", bus4.done); end
  endtask

  task automatic test_slt();
    logic [W-1:0] va [3] = '{8'hFE, 8'h80, 8'h01};
    logic [W-1:0] vb [3] = '{8'h01, 8'h7F, 8'hFE};
    logic [W-1:0] vr [3] = '{8'h01, 8'h01, 8'h00};
    exp_t got, e;
    int   cyc;
    for (int i = 0; i < 3; i++) begin
      issue1(va[i], vb[i], 1'b1, 4'b0111, model(va[i], vb[i], 1'b1, 4'b0111));
      collect1(got, cyc);
      e = q1.pop_front();
      testsRun++;
      if (got.r !== vr[i]) begin testsFailed++; $display("[TB] FAIL slt_%0d_result: got %h, expected %h", i, got.r, vr[i]); end
      testsRun++;
      if (got !== e) begin testsFailed++; $display("[TB] FAIL slt_%0d_flags: got r=%h c=%b o=%b z=%b, expected r=%h c=%b o=%b z=%b", i, got.r, got.c, got.o, got.z, e.r, e.c, e.o, e.z); end
    end
  endtask

  task automatic test_logic();
    logic [3:0]   ctl [2] = '{4'b1100, 4'b0001};
    logic [W-1:0] vr  [2] = '{8'h03, 8'hFC};
    exp_t got, e;
    int   cyc;
    for (int i = 0; i < 2; i++) begin
      issue1(8'hF0, 8'h0C, 1'b0, ctl[i], model(8'hF0, 8'h0C, 1'b0, ctl[i]));
      collect1(got, cyc);
      e = q1.pop_front();
      testsRun++;
      if (got.r !== vr[i]) begin testsFailed++; $display("[TB] FAIL logic_%0d_result: got %h, expected %h", i, got.r, vr[i]); end
      testsRun++;
      if (got !== e) begin testsFailed++; $display("[TB] FAIL logic_%0d_flags: got r=%h c=%b o=%b z=%b, expected r=%h c=%b o=%b z=%b", i, got.r, got.c, got.o, got.z, e.r, e.c, e.o, e.z); end
    end
  endtask

  task automatic test_reset_midop();
    exp_t got, e;
    int   cyc;
    logic sawDone;
    issue1(8'h3C, 8'h11, 1'b0, 4'b0010, model(8'h3C, 8'h11, 1'b0, 4'b0010));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    testsRun++;
    if ({bus1.result, bus1.cout, bus1.ovf, bus1.zero, bus1.busy, bus1.done} !== 13'd0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_outputs: got r=%h c=%b o=%b z=%b busy=%b done=%b, expected all 0", bus1.result, bus1.cout, bus1.ovf, bus1.zero, bus1.busy, bus1.done);
    end
    q1.delete();
    @(negedge clk);
    rst_n   = 1'b1;
    sawDone = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus1.done === 1'b1) sawDone = 1'b1;
    end
    testsRun++;
    if (sawDone !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_no_done: got %b, expected 0", sawDone); end
    issue1(8'h22, 8'h33, 1'b0, 4'b0010, model(8'h22, 8'h33, 1'b0, 4'b0010));
    collect1(got, cyc);
    testsRun++;
    if (cyc != 9) begin testsFailed++; $display("[TB] FAIL midreset_restart_latency: got cycle %0d, expected 9", cyc); end
    e = q1.pop_front();
    testsRun++;
    if (got !== e) begin testsFailed++; $display("[TB] FAIL midreset_restart_value: got r=%h c=%b o=%b z=%b, expected r=%h c=%b o=%b z=%b", got.r, got.c, got.o, got.z, e.r, e.c, e.o, e.z); end
  endtask

  task automatic test_back_to_back();
    exp_t got, e;
    logic [W-1:0] lastRes;
    logic expDone;
    logic [W-1:0] na, nb;
    logic ncin;
    logic [3:0] nctl;
    @(negedge clk);
    lastRes = bus1.result;
    for (int c = 0; c < 30; c++) begin
      expDone = (c == 9) || (c == 18) || (c == 27);
      testsRun++;
      if (bus1.done !== expDone) begin testsFailed++; $display("[TB] FAIL b2b_done cycle %0d: got %b, expected %b", c, bus1.done, expDone); end
      if (bus1.done === 1'b1) begin
        got = '{bus1.result, bus1.cout, bus1.ovf, bus1.zero};
        testsRun++;
        if (q1.size() == 0) begin
          testsFailed++; $display("[TB] FAIL b2b_extra_done cycle %0d: got done, expected none queued", c);
        end else begin
          e = q1.pop_front();
          if (got !== e) begin testsFailed++; $display("[TB] FAIL b2b_value cycle %0d: got r=%h c=%b o=%b z=%b, expected r=%h c=%b o=%b z=%b", c, got.r, got.c, got.o, got.z, e.r, e.c, e.o, e.z); end
        end
        lastRes = bus1.result;
      end else begin
        testsRun++;
        if (bus1.result !== lastRes) begin testsFailed++; $display("[TB] FAIL b2b_hold cycle %0d: got %h, expected %h", c, bus1.result, lastRes); end
      end
      if (c < 20) begin
        na   = W'($urandom);
        nb   = W'($urandom);
        ncin = 1'($urandom_range(0, 1));
        nctl = 4'($urandom_range(0, 15));
        bus1.start = 1'b1; bus1.a = na; bus1.b = nb; bus1.cin = ncin; bus1.control = nctl;
        if (c == 0 || c == 9 || c == 18) q1.push_back(model(na, nb, ncin, nctl));
      end else begin
        bus1.start = 1'b0;
      end
      @(negedge clk);
    end
    testsRun++;
    if (q1.size() != 0) begin testsFailed++; $display("[TB] FAIL b2b_pending: got %0d outstanding, expected 0", q1.size()); end
  endtask

  initial begin
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.control = '0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.control = '0;
    test_reset();
    test_add();
    test_sub();
    test_sub_slice4();
    test_slt();
    test_logic();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
